// File: rtl/idmem_arbiter.sv
// Round-robin arbiter sharing one instruction/data memory between the cpu and the loader,
// with a loader lock mode. Optional lock timeout when MEMARB_LOCK_TIMEOUT_EN is defined.
module idmem_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic              ld_lock,
   input  logic [31:0]       ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {ARB, LOCK} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LD} owner_t;

   state_t state, state_nxt;
   logic   prio, prio_nxt;
   owner_t rd_owner;

`ifdef MEMARB_LOCK_TIMEOUT_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
   logic             timeout;

   assign timeout = (state == LOCK) && (lock_cnt == CNT_W'(LOCK_MAX)) && cpu_req;
`else
   logic unused_lock_max;
   assign unused_lock_max = (LOCK_MAX > 0);
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      cpu_gnt   = 1'b0;
      ld_gnt    = 1'b0;
      state_nxt = state;
      prio_nxt  = prio;
`ifdef MEMARB_LOCK_TIMEOUT_EN
      lock_cnt_nxt = lock_cnt;
`endif
      if (!reset) begin
         case (state)
            ARB: begin
               if (cpu_req && ld_req) begin
                  // prio=0 lets the cpu win; the loser wins the next tie.
                  cpu_gnt  = !prio;
                  ld_gnt   = prio;
                  prio_nxt = !prio;
               end else begin
                  cpu_gnt = cpu_req;
                  ld_gnt  = ld_req;
               end
               if (ld_gnt && ld_lock) state_nxt = LOCK;
`ifdef MEMARB_LOCK_TIMEOUT_EN
               lock_cnt_nxt = '0;
`endif
            end
            LOCK: begin
               ld_gnt = ld_req;
`ifdef MEMARB_LOCK_TIMEOUT_EN
               if (timeout) begin
                  cpu_gnt      = 1'b1;
                  ld_gnt       = 1'b0;
                  lock_cnt_nxt = '0;
               end else if (lock_cnt != CNT_W'(LOCK_MAX)) begin
                  lock_cnt_nxt = lock_cnt + 1'b1;
               end
`endif
               if (!ld_lock) begin
                  state_nxt = ARB;
`ifdef MEMARB_LOCK_TIMEOUT_EN
                  lock_cnt_nxt = '0;
`endif
               end
            end
            default: state_nxt = ARB;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ARB;
         prio     <= 1'b0;
         rd_owner <= OWN_NONE;
`ifdef MEMARB_LOCK_TIMEOUT_EN
         lock_cnt <= '0;
`endif
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
`ifdef MEMARB_LOCK_TIMEOUT_EN
         lock_cnt <= lock_cnt_nxt;
`endif
         if (cpu_gnt && !cpu_we)     rd_owner <= OWN_CPU;
         else if (ld_gnt && !ld_we)  rd_owner <= OWN_LD;
         else                        rd_owner <= OWN_NONE;
      end
   end

   // A reset landing in the return cycle suppresses the pending rvalid.
   assign cpu_rvalid = (rd_owner == OWN_CPU) && !reset;
   assign ld_rvalid  = (rd_owner == OWN_LD) && !reset;
   assign cpu_rdata  = mem_rdata;
   assign ld_rdata   = mem_rdata;

   assign mem_en    = cpu_gnt || ld_gnt;
   assign mem_we    = ld_gnt ? ld_we : (cpu_gnt && cpu_we);
   assign mem_addr  = ld_gnt ? ld_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
   assign mem_wdata = ld_gnt ? ld_wdata : cpu_wdata;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                               ld_addr[31:ADDR_W+2], ld_addr[1:0]};

endmodule

// File: tb/tb_idmem_arbiter.sv
// Self-checking bench for idmem_arbiter: rule-level reference model for grants plus a
// read-return scoreboard drained by an independent monitor.
module tb_idmem_arbiter;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 32;
   localparam int LOCK_MAX = 16;
`ifdef MEMARB_LOCK_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [31:0]       cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
   logic [31:0]       ld_addr;
   logic [DATA_W-1:0] ld_wdata, ld_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   idmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
      .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Memory attached to the DUT, and the bench's own copy of what it should contain.
   logic [DATA_W-1:0] mem     [256];
   logic [DATA_W-1:0] ref_mem [256];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      bit          rst, creq, cwe;
      logic [31:0] caddr, cwd;
      bit          lreq, lwe, llock;
      logic [31:0] laddr, lwd;
   } stim_t;

   typedef struct {
      int          owner;
      logic [31:0] data;
   } rd_t;

   rd_t rd_q[$];
   int  checks   = 0;
   int  failures = 0;

   // Reference model state, expressed as rules rather than registers.
   bit m_locked   = 1'b0;
   bit m_ld_first = 1'b0;
   int m_age      = 0;
   int m_prev_rd  = 0;
   bit obs_cpu_gnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // 0 = nobody, 1 = cpu, 2 = loader
   function automatic int ref_winner(input bit creq, input bit lreq);
      if (m_locked) begin
         if (TIMEOUT_EN && m_age == LOCK_MAX && creq) return 1;
         return lreq ? 2 : 0;
      end
      if (creq && lreq) return m_ld_first ? 2 : 1;
      if (creq) return 1;
      if (lreq) return 2;
      return 0;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{rst: 1'b0, creq: 1'b0, cwe: 1'b0, caddr: 32'h0, cwd: 32'h0,
            lreq: 1'b0, lwe: 1'b0, llock: 1'b0, laddr: 32'h0, lwd: 32'h0};
      return s;
   endfunction

   task automatic step(input stim_t s);
      int          win;
      bit          exp_we;
      logic [7:0]  exp_addr;
      logic [31:0] exp_wd;
      @(posedge clk);
      #1;
      reset = s.rst;
      cpu_req = s.creq; cpu_we = s.cwe; cpu_addr = s.caddr; cpu_wdata = s.cwd;
      ld_req = s.lreq; ld_we = s.lwe; ld_lock = s.llock; ld_addr = s.laddr; ld_wdata = s.lwd;
      if (s.rst) rd_q.delete();
      win      = s.rst ? 0 : ref_winner(s.creq, s.lreq);
      exp_we   = (win == 1) ? s.cwe : (win == 2) ? s.lwe : 1'b0;
      exp_addr = (win == 2) ? s.laddr[9:2] : s.caddr[9:2];
      exp_wd   = (win == 2) ? s.lwd : s.cwd;
      if (win != 0 && !exp_we) rd_q.push_back('{owner: win, data: ref_mem[exp_addr]});
      if (win != 0 && exp_we) ref_mem[exp_addr] = exp_wd;
      @(negedge clk);
      check("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, win == 1});
      check("ld_gnt", {31'b0, ld_gnt}, {31'b0, win == 2});
      check("mem_en", {31'b0, mem_en}, {31'b0, win != 0});
      check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
      if (win != 0) check("mem_addr", {24'b0, mem_addr}, {24'b0, exp_addr});
      if (win != 0 && exp_we) check("mem_wdata", mem_wdata, exp_wd);
      check("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_prev_rd == 1 && !s.rst});
      check("ld_rvalid", {31'b0, ld_rvalid}, {31'b0, m_prev_rd == 2 && !s.rst});
      obs_cpu_gnt = cpu_gnt;
      if (s.rst) begin
         m_locked = 1'b0; m_ld_first = 1'b0; m_age = 0; m_prev_rd = 0;
      end else begin
         m_prev_rd = (win != 0 && !exp_we) ? win : 0;
         if (!m_locked) begin
            if (s.creq && s.lreq) m_ld_first = (win == 1);
            if (win == 2 && s.llock) begin m_locked = 1'b1; m_age = 0; end
         end else if (!s.llock) begin
            m_locked = 1'b0; m_age = 0;
         end else if (TIMEOUT_EN && win == 1) begin
            m_age = 0;
         end else if (m_age < LOCK_MAX) begin
            m_age++;
         end
      end
   endtask

   // Monitor: whenever read data is presented, pop the oldest expected read and compare.
   initial begin
      rd_t e;
      forever begin
         @(negedge clk);
         if (cpu_rvalid || ld_rvalid) begin
            check("rvalid_both", {31'b0, cpu_rvalid & ld_rvalid}, 32'h0);
            if (rd_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rd_unexpected: got rvalid with no read outstanding at %0t", $time);
            end else begin
               e = rd_q.pop_front();
               check("rd_owner", ld_rvalid ? 32'd2 : 32'd1, e.owner);
               check("rd_data", ld_rvalid ? ld_rdata : cpu_rdata, e.data);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t    s;
      int       cnt;
      bit [3:0] pat;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'h1000_0000 + i * 32'h0001_0203;
         ref_mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
      end
      mem[4]     = 32'hDEADBEEF;
      ref_mem[4] = 32'hDEADBEEF;
      s = idle();
      s.rst = 1'b1;
      step(s);
      step(s);

      // Single cpu read of word 4.
      s = idle(); s.creq = 1'b1; s.caddr = 32'h10;
      step(s);
      check("t1_mem_addr", {24'b0, mem_addr}, 32'd4);
      step(idle());

      // Contention after reset: cpu, ld, cpu, ld.
      pat = '0;
      for (int i = 0; i < 4; i++) begin
         s = idle(); s.creq = 1'b1; s.lreq = 1'b1;
         s.caddr = $urandom; s.laddr = $urandom;
         step(s);
         pat = {pat[2:0], obs_cpu_gnt};
      end
      check("contention_pattern", {28'b0, pat}, 32'hA);

      // Hand the next tie to the loader, then a locked 8-word load against a waiting cpu.
      s = idle(); s.creq = 1'b1; s.lreq = 1'b1;
      step(s);
      cnt = 0;
      for (int i = 0; i < 9; i++) begin
         s = idle(); s.creq = 1'b1; s.caddr = 32'h40;
         if (i < 8) begin
            s.lreq = 1'b1; s.lwe = 1'b1; s.llock = 1'b1;
            s.laddr = 32'(i * 4); s.lwd = 32'(i + 1);
         end
         step(s);
         cnt += int'(obs_cpu_gnt);
      end
      check("lock_cpu_gnts", cnt, 0);
      s = idle(); s.creq = 1'b1; s.caddr = 32'h44;
      step(s);
      check("lock_release_gnt", {31'b0, obs_cpu_gnt}, 32'd1);

      // Long lock with the cpu waiting: timeout grants only when enabled.
      s = idle(); s.lreq = 1'b1; s.llock = 1'b1; s.laddr = 32'h80;
      step(s);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         s = idle(); s.creq = 1'b1; s.caddr = $urandom;
         s.lreq = 1'b1; s.lwe = 1'b1; s.llock = 1'b1;
         s.laddr = 32'h100 + 32'(i * 4); s.lwd = $urandom;
         step(s);
         cnt += int'(obs_cpu_gnt);
      end
      check("timeout_cpu_gnts", cnt, TIMEOUT_EN ? 32'd2 : 32'd0);
      step(idle());

      // Reset in the cycle after a cpu read: rvalid dropped, priority back to cpu.
      for (int i = 0; i < 2 && !m_ld_first; i++) begin
         s = idle(); s.creq = 1'b1; s.lreq = 1'b1;
         step(s);
      end
      s = idle(); s.creq = 1'b1; s.caddr = 32'h8;
      step(s);
      s = idle(); s.rst = 1'b1;
      step(s);
      check("reset_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      s = idle(); s.creq = 1'b1; s.lreq = 1'b1;
      step(s);
      check("reset_prio_cpu", {31'b0, obs_cpu_gnt}, 32'd1);

      // Write immediately followed by a read of the same word.
      s = idle(); s.creq = 1'b1; s.cwe = 1'b1; s.caddr = 32'h20; s.cwd = 32'hCAFEF00D;
      step(s);
      s = idle(); s.creq = 1'b1; s.caddr = 32'h20;
      step(s);
      step(idle());
      check("wr_rd_ref", ref_mem[8], 32'hCAFEF00D);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         s = idle();
         s.rst   = ($urandom_range(0, 99) == 0);
         s.creq  = ($urandom_range(0, 3) != 0);
         s.cwe   = $urandom_range(0, 1) == 1;
         s.caddr = $urandom;
         s.cwd   = $urandom;
         s.lreq  = ($urandom_range(0, 2) != 0);
         s.lwe   = $urandom_range(0, 1) == 1;
         s.llock = m_locked ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
         s.laddr = $urandom;
         s.lwd   = $urandom;
         step(s);
      end
      step(idle());
      step(idle());
      check("rd_q_drained", rd_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/idmem_arbiter.md
# idmem_arbiter

Two-port arbiter sharing the single-port, unified instruction/data memory between the multi-cycle MIPS core (requester 0, "cpu") and the program loader/debug port (requester 1, "ld"). Sits between the core's memory interface and the memory. It grants at most one access per cycle, using round-robin arbitration plus a loader lock mode. It returns synchronous read data to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 8, word-address width of the memory; byte address bits [ADDR_W+1:2] are used.
- DATA_W, 32, data width.
- LOCK_MAX, 16, lock-timeout threshold in cycles; used only with MEMARB_LOCK_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req, cpu_we  in  1  cpu access request / write enable.
- cpu_addr  in  32  cpu byte address.
- cpu_wdata  in  DATA_W  cpu write data.
- cpu_gnt  out  1  cpu access accepted this cycle (combinational).
- cpu_rvalid  out  1  cpu read data valid (registered).
- cpu_rdata  out  DATA_W  equals mem_rdata.
- ld_req, ld_we, ld_lock  in  1  loader request / write enable / exclusive-lock request.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  DATA_W  loader write data.
- ld_gnt, ld_rvalid  out  1  loader grant (combinational) / loader read valid (registered).
- ld_rdata  out  DATA_W  equals mem_rdata.
- mem_en, mem_we  out  1  memory enable / write enable.
- mem_addr  out  ADDR_W  word address of the granted request.
- mem_wdata  out  DATA_W  write data of the granted request.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.

## Operation
- **State:**
  - FSM state is ARB or LOCK.
  - prio is a 1-bit register: 0 means cpu wins ties.
  - lock_cnt counts cycles spent in LOCK.
  - rd_owner holds cpu/ld/none.
- **ARB:**
  - A single requester is granted.
  - On contention, the prio side is granted, and prio is set to the loser.
  - prio is unchanged when there is no contention.
- **ARB->LOCK:** at the edge ending a cycle where ld_gnt=1 and ld_lock=1.
- **LOCK:**
  - cpu_gnt=0.
  - ld_gnt=ld_req.
  - LOCK->ARB at the edge ending a cycle with ld_lock=0.
  - lock_cnt clears on entry to LOCK and on exit from LOCK.
- **Memory drive (grant):** mem_en=1. mem_we, mem_addr (addr[ADDR_W+1:2]) and mem_wdata come from the granted requester, in the same cycle as the grant.
- **No grant:** mem_en=0 and mem_we=0.
- **Read return:**
  - A granted read (we=0) sets rd_owner.
  - The next cycle asserts the owner's rvalid for exactly 1 cycle.
  - Writes never produce rvalid.
- **Address range:** address bits above ADDR_W+1 and bits [1:0] are ignored. Accesses are not checked for range.

## Timing
- Grant is combinational with the request. Read latency is 1 cycle from grant to rvalid.
- Back-to-back grants carry no bubble, including across requesters and when a read is followed by a write.
- **Reset:**
  - While reset=1: cpu_gnt=ld_gnt=0, mem_en=mem_we=0.
  - Registers go to: state=ARB, prio=0, lock_cnt=0, rd_owner=none, cpu_rvalid=ld_rvalid=0.
  - Reset in the cycle after a read grant drops that rvalid.
- **Lock edge cases:**
  - ld_lock with no ld_gnt (e.g. the cpu wins the tie) does not enter LOCK.
  - ld_lock may be held without ld_req; LOCK persists and the memory idles.

## Configuration
- **MEMARB_LOCK_TIMEOUT_EN defined:**
  - In LOCK, lock_cnt increments every cycle, saturating at LOCK_MAX.
  - When lock_cnt==LOCK_MAX and cpu_req=1, the cpu is granted that cycle, ld_gnt=0, lock_cnt is cleared, and the state stays LOCK.
- **MEMARB_LOCK_TIMEOUT_EN undefined:** lock_cnt is absent and LOCK excludes the cpu indefinitely.

## Test plan
- **Single cpu read:** memory word 4 = 0xDEADBEEF; cpu read of 0x10 -> cpu_gnt=1, mem_addr=4 in cycle 0; cpu_rvalid=1, cpu_rdata=0xDEADBEEF in cycle 1; ld_rvalid stays 0.
- **Contention after reset:** cpu_req and ld_req held high, ld_lock=0, for 4 cycles -> grants cpu, ld, cpu, ld.
- **Lock:**
  - Loader writes 0x1..0x8 to addresses 0x0-0x1C with ld_lock=1 while cpu_req is held -> cpu_gnt=0 throughout.
  - ld_lock falls in cycle 8 -> cpu_gnt=1 in cycle 9.
- **Timeout (macro defined, LOCK_MAX=16):** LOCK held 40 cycles with cpu_req=1 -> cpu granted on lock cycles 16 and 33. With the macro undefined -> no cpu grant.
- **Reset after read:** reset asserted the cycle after a cpu read grant -> cpu_rvalid=0. The next contention grants the cpu first.
- **Write then read:** cpu writes 0xCAFEF00D to 0x20, then reads 0x20 in the next cycle -> rvalid with 0xCAFEF00D.
